// File: rtl/bp_be_acc_dispatch.sv
// Accelerator command dispatch: queues retired CUSTOM0 commands, meters outstanding
// responses, and buffers one accelerator result for register writeback.
module bp_be_acc_dispatch #(
    parameter int els_p         = 4,
    parameter int instr_width_p = 32,
    parameter int dword_width_p = 64,
    parameter int wide_width_p  = 512
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     acc_v_i,
    input  logic [instr_width_p-1:0] acc_instr_i,
    input  logic [dword_width_p-1:0] acc_data_i,
    input  logic                     acc_wide_v_i,
    input  logic [wide_width_p-1:0]  acc_wide_data_i,

    output logic                     cmd_v_o,
    output logic [instr_width_p-1:0] cmd_instr_o,
    output logic [dword_width_p-1:0] cmd_data_o,
    output logic [wide_width_p-1:0]  cmd_wide_o,
    input  logic                     cmd_ready_i,

    input  logic                     resp_v_i,
    input  logic [4:0]               resp_rd_i,
    input  logic [dword_width_p-1:0] resp_data_i,
    output logic                     resp_ready_o,

    output logic                     wb_v_o,
    output logic [4:0]               wb_rd_o,
    output logic [dword_width_p-1:0] wb_data_o,
    input  logic                     wb_yumi_i,

    output logic                     full_o,
    output logic                     busy_o,
    output logic                     overflow_o
);

    localparam int lg_els_lp = $clog2(els_p);
    localparam int cnt_w_lp  = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] els_c = cnt_w_lp'(els_p);

    logic [lg_els_lp-1:0]     wptr_q, wptr_d;
    logic [lg_els_lp-1:0]     rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]      count_q, count_d;
    logic [cnt_w_lp-1:0]      outst_q, outst_d;
    logic                     ovf_q, ovf_d;
    logic                     buf_v_q, buf_v_d;
    logic [4:0]               buf_rd_q, buf_rd_d;
    logic [dword_width_p-1:0] buf_data_q, buf_data_d;
    logic [wide_width_p-1:0]  wide_q, wide_d;

    logic [instr_width_p-1:0] instr_mem_q [els_p];
    logic [dword_width_p-1:0] data_mem_q  [els_p];

    logic fifo_empty, fifo_full;
    logic cmd_v, deq, enq, drop;
    logic head_expects, resp_ready, resp_hs;

    always_comb begin
        fifo_empty   = (count_q == '0);
        fifo_full    = (count_q == els_c);
        // Stop issuing once every response slot is claimed, so results can never be lost.
        cmd_v        = !fifo_empty && (outst_q < els_c);
        deq          = cmd_v && cmd_ready_i;
        enq          = acc_v_i && (!fifo_full || deq);
        drop         = acc_v_i && fifo_full && !deq;
        head_expects = instr_mem_q[rptr_q][14] && (instr_mem_q[rptr_q][11:7] != 5'd0);
        resp_ready   = (outst_q != '0) && (!buf_v_q || wb_yumi_i);
        resp_hs      = resp_v_i && resp_ready;
    end

    always_comb begin
        wptr_d  = enq ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = deq ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        case ({deq && head_expects, resp_hs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        buf_v_d    = buf_v_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        // A fresh result takes priority over the writeback drain in the same cycle.
        if (resp_hs) begin
            buf_v_d    = 1'b1;
            buf_rd_d   = resp_rd_i;
            buf_data_d = resp_data_i;
        end else if (wb_yumi_i) begin
            buf_v_d    = 1'b0;
        end
    end

    always_comb begin
        ovf_d  = ovf_q || drop;
        wide_d = acc_wide_v_i ? acc_wide_data_i : wide_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            outst_q <= '0;
            ovf_q   <= 1'b0;
            buf_v_q <= 1'b0;
            wide_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            outst_q <= outst_d;
            ovf_q   <= ovf_d;
            buf_v_q <= buf_v_d;
            wide_q  <= wide_d;
        end
    end

    // Payload storage carries no reset; it is qualified by the control state above.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            instr_mem_q[wptr_q] <= acc_instr_i;
            data_mem_q[wptr_q]  <= acc_data_i;
        end
        buf_rd_q   <= buf_rd_d;
        buf_data_q <= buf_data_d;
    end

    assign cmd_v_o      = cmd_v;
    assign cmd_instr_o  = instr_mem_q[rptr_q];
    assign cmd_data_o   = data_mem_q[rptr_q];
    assign cmd_wide_o   = wide_q;
    assign resp_ready_o = resp_ready;
    assign wb_v_o       = buf_v_q;
    assign wb_rd_o      = buf_rd_q;
    assign wb_data_o    = buf_data_q;
    assign full_o       = fifo_full;
    assign busy_o       = !fifo_empty || (outst_q != '0) || buf_v_q;
    assign overflow_o   = ovf_q;

endmodule
